dct_zigzag_out: RTL and testbench

Output serializer placed directly downstream of the 64-point 2-D DCT core. It captures the 64 parallel 24-bit coefficients the core presents once per block, on the cycle `clk_cnt` equals `CNT_CLK`. It then streams them one per beat in JPEG zigzag order over a valid/ready interface. Two storage banks let one block be captured while the previous block is still draining, which absorbs back-pressure from the quantizer/entropy stage.

---
 rtl/dct_zigzag_out.sv | 136 +++++++++++++
 tb/tb_dct_zigzag_out.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_zigzag_out.sv
// dct_zigzag_out: double-buffered serializer for 8x8 DCT coefficient blocks.
// A block is captured in parallel on the cycle clk_cnt hits CNT_CLK. It is
// then streamed one coefficient per beat in JPEG zigzag order over
// valid/ready. Two banks let a new block land while the previous one is
// still draining under back-pressure.
module dct_zigzag_out #(
  parameter int CNT_CLK = 0,
  parameter int DATA_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        clk_cnt,
  input  logic [DATA_W-1:0] i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,
  input  logic [DATA_W-1:0] i8,  i9,  i10, i11, i12, i13, i14, i15,
  input  logic [DATA_W-1:0] i16, i17, i18, i19, i20, i21, i22, i23,
  input  logic [DATA_W-1:0] i24, i25, i26, i27, i28, i29, i30, i31,
  input  logic [DATA_W-1:0] i32, i33, i34, i35, i36, i37, i38, i39,
  input  logic [DATA_W-1:0] i40, i41, i42, i43, i44, i45, i46, i47,
  input  logic [DATA_W-1:0] i48, i49, i50, i51, i52, i53, i54, i55,
  input  logic [DATA_W-1:0] i56, i57, i58, i59, i60, i61, i62, i63,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun
);

  localparam logic [3:0] CAP_CNT = 4'(CNT_CLK);

  // Zigzag position -> raster index (row*8 + column).
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_W-1:0] in_blk [64];
  logic [DATA_W-1:0] bank_q [2][64];

  state_t     state_q, state_d;
  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [5:0] rd_pos_q, rd_pos_d;
  logic       overrun_q, overrun_d;

  logic cap, hs, last_hs, wr_free, cap_acc;

  assign in_blk = '{
    i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,  i8,  i9,  i10, i11, i12, i13, i14, i15,
    i16, i17, i18, i19, i20, i21, i22, i23, i24, i25, i26, i27, i28, i29, i30, i31,
    i32, i33, i34, i35, i36, i37, i38, i39, i40, i41, i42, i43, i44, i45, i46, i47,
    i48, i49, i50, i51, i52, i53, i54, i55, i56, i57, i58, i59, i60, i61, i62, i63
  };

  // Capture and handshake strobes; a bank whose last beat retires this edge
  // already counts as free for an incoming block.
  always_comb begin
    cap     = (clk_cnt == CAP_CNT);
    hs      = (state_q == STREAM) && out_ready;
    last_hs = hs && (rd_pos_q == 6'd63);
    wr_free = !full_q[wr_sel_q] || (last_hs && (rd_sel_q == wr_sel_q));
    cap_acc = cap && wr_free;
  end

  // Next-state: bank bookkeeping, read pointer and read FSM.
  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    rd_pos_d  = rd_pos_q;
    overrun_d = overrun_q;

    if (hs) rd_pos_d = rd_pos_q + 6'd1;
    if (last_hs) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    // Set after the clear so a same-edge refill of the freed bank wins.
    if (cap_acc) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else if (cap) begin
      overrun_d = 1'b1;
    end

    if (state_q == IDLE) begin
      if (full_q[rd_sel_q]) state_d = STREAM;
    end else begin
      // Stay streaming straight into the other bank so there is no bubble.
      if (last_hs && !full_q[~rd_sel_q]) state_d = IDLE;
    end
  end

  // Control state; async reset discards both banks by clearing full flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      full_q    <= 2'b00;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_pos_q  <= 6'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      rd_pos_q  <= rd_pos_d;
      overrun_q <= overrun_d;
    end
  end

  // Coefficient storage; contents are only meaningful while the bank is full.
  always_ff @(posedge clk) begin
    if (cap_acc) begin
      for (int k = 0; k < 64; k++) bank_q[wr_sel_q][k] <= in_blk[k];
    end
  end

  assign out_valid = (state_q == STREAM);
  assign out_idx   = rd_pos_q;
  assign out_last  = out_valid && (rd_pos_q == 6'd63);
  assign out_data  = out_valid ? bank_q[rd_sel_q][ZZ[rd_pos_q]] : '0;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dct_zigzag_out.sv
// Bench for dct_zigzag_out: directed scenarios plus randomized traffic,
// checked every cycle against a block-queue model of the serializer.
module tb_dct_zigzag_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cnt;
  logic [23:0] blk [64];
  logic        ready;
  logic [23:0] out_data;
  logic [5:0]  out_idx;
  logic        out_valid, out_last, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dct_zigzag_out #(.CNT_CLK(0), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .clk_cnt(cnt),
    .i0(blk[0]),   .i1(blk[1]),   .i2(blk[2]),   .i3(blk[3]),   .i4(blk[4]),   .i5(blk[5]),   .i6(blk[6]),   .i7(blk[7]),
    .i8(blk[8]),   .i9(blk[9]),   .i10(blk[10]), .i11(blk[11]), .i12(blk[12]), .i13(blk[13]), .i14(blk[14]), .i15(blk[15]),
    .i16(blk[16]), .i17(blk[17]), .i18(blk[18]), .i19(blk[19]), .i20(blk[20]), .i21(blk[21]), .i22(blk[22]), .i23(blk[23]),
    .i24(blk[24]), .i25(blk[25]), .i26(blk[26]), .i27(blk[27]), .i28(blk[28]), .i29(blk[29]), .i30(blk[30]), .i31(blk[31]),
    .i32(blk[32]), .i33(blk[33]), .i34(blk[34]), .i35(blk[35]), .i36(blk[36]), .i37(blk[37]), .i38(blk[38]), .i39(blk[39]),
    .i40(blk[40]), .i41(blk[41]), .i42(blk[42]), .i43(blk[43]), .i44(blk[44]), .i45(blk[45]), .i46(blk[46]), .i47(blk[47]),
    .i48(blk[48]), .i49(blk[49]), .i50(blk[50]), .i51(blk[51]), .i52(blk[52]), .i53(blk[53]), .i54(blk[54]), .i55(blk[55]),
    .i56(blk[56]), .i57(blk[57]), .i58(blk[58]), .i59(blk[59]), .i60(blk[60]), .i61(blk[61]), .i62(blk[62]), .i63(blk[63]),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(ready), .out_last(out_last), .overrun(overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Zigzag order derived by walking anti-diagonals of the 8x8 grid.
  int zz [64];

  // Pending blocks as a flat queue of zigzag-ordered values; each block
  // becomes visible one edge after capture, or immediately when the block
  // ahead of it retires if it was already stored by then.
  logic [23:0] dq [$];
  int          cap_q [$];
  int          nblk = 0;
  int          mpos = 0;
  int          head_start = 0;
  int          edge_n = 0;
  logic        m_ovr = 1'b0;
  bit          fresh = 1'b1;

  function automatic bit m_visible();
    return (nblk > 0) && (edge_n >= head_start);
  endfunction

  initial begin
    bit v, hs, lst, capt, acc;
    logic [23:0] tmp_d;
    int tmp_i;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        dq.delete(); cap_q.delete();
        nblk = 0; mpos = 0; head_start = 0; edge_n = 0; m_ovr = 1'b0; fresh = 1'b1;
      end else begin
        v    = m_visible();
        edge_n++;
        hs   = v && ready;
        lst  = hs && (mpos == 63);
        capt = (cnt == 4'd0);
        acc  = capt && ((nblk < 2) || lst);
        if (hs) begin tmp_d = dq.pop_front(); mpos++; end
        if (lst) begin
          mpos = 0;
          nblk--;
          tmp_i = cap_q.pop_front();
          if (nblk > 0) head_start = (cap_q[0] + 1 > edge_n) ? cap_q[0] + 1 : edge_n;
        end
        if (acc) begin
          for (int p = 0; p < 64; p++) dq.push_back(blk[zz[p]]);
          cap_q.push_back(edge_n);
          nblk++;
          fresh = 1'b0;
          if (nblk == 1) head_start = edge_n + 1;
        end else if (capt) begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      ev = m_visible();
      check("out_valid", {63'd0, out_valid}, {63'd0, ev});
      if (ev) begin
        check("out_data", {40'd0, out_data}, {40'd0, dq[0]});
        check("out_idx", {58'd0, out_idx}, 64'(mpos));
        check("out_last", {63'd0, out_last}, {63'd0, (mpos == 63)});
      end else begin
        check("out_last_idle", {63'd0, out_last}, 64'd0);
        if (fresh) begin
          check("out_data_rst", {40'd0, out_data}, 64'd0);
          check("out_idx_rst", {58'd0, out_idx}, 64'd0);
        end
      end
      check("overrun", {63'd0, overrun}, {63'd0, m_ovr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic capture();
    cnt = 4'd0; step(1); cnt = 4'd7;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0; step(1);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 64; k++) blk[k] = 24'(k);
  endtask

  task automatic fill_const(input logic [23:0] v);
    for (int k = 0; k < 64; k++) blk[k] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 64; k++) blk[k] = 24'($urandom);
  endtask

  initial begin
    int p, hs_cnt, run, maxrun;
    bit found;
    int lo, hi;

    // Build zigzag order from anti-diagonals.
    p = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[p] = r * 8 + (s - r); p++; end
      else            for (int r = lo; r <= hi; r++) begin zz[p] = r * 8 + (s - r); p++; end
    end
    check("zz0",  64'(zz[0]),  64'd0);
    check("zz2",  64'(zz[2]),  64'd8);
    check("zz5",  64'(zz[5]),  64'd2);
    check("zz9",  64'(zz[9]),  64'd24);
    check("zz61", 64'(zz[61]), 64'd55);
    check("zz63", 64'(zz[63]), 64'd63);

    rst = 1'b1; ready = 1'b0; cnt = 4'd7; fill_const(24'd0);
    step(3);
    rst = 1'b0;
    step(2);

    // Ramp block, consumer always ready.
    fill_ramp(); ready = 1'b1; capture(); step(70);

    // Back-pressure pattern 1,0,0,1.
    fill_ramp(); hs_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      ready = (c % 4 == 0) || (c % 4 == 3);
      cnt = (c == 0) ? 4'd0 : 4'd7;
      if (out_valid && ready) hs_cnt++;
      step(1);
    end
    check("bp_handshakes", 64'(hs_cnt), 64'd64);
    cnt = 4'd7;

    // Back-to-back blocks, no bubble at the bank switch.
    ready = 1'b1; run = 0; maxrun = 0;
    for (int c = 0; c < 220; c++) begin
      if (c == 0)  begin fill_const(24'h000001); cnt = 4'd0; end
      else if (c == 63) begin fill_const(24'hFFFFFF); cnt = 4'd0; end
      else cnt = 4'd7;
      if (out_valid) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      step(1);
    end
    check("b2b_contiguous", 64'(maxrun), 64'd128);
    cnt = 4'd7;

    // Overrun: third block dropped while stalled.
    do_reset();
    ready = 1'b0;
    fill_rand(); capture(); step(2);
    fill_rand(); capture(); step(2);
    check("overrun_before", {63'd0, overrun}, 64'd0);
    fill_rand(); capture();
    check("overrun_set", {63'd0, overrun}, 64'd1);
    ready = 1'b1; step(200);

    // Capture coinciding with the final handshake of the read bank.
    do_reset();
    ready = 1'b0;
    fill_rand(); capture(); step(2);
    fill_rand(); capture(); step(2);
    ready = 1'b1; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_visible() && mpos == 63 && nblk == 2) found = 1'b1;
      else step(1);
    end
    check("simul_reach", {63'd0, found}, 64'd1);
    fill_rand(); capture();
    check("simul_no_overrun", {63'd0, overrun}, 64'd0);
    step(200);

    // Reset at beat 20 of a block.
    do_reset();
    ready = 1'b1; fill_rand(); capture(); found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_visible() && mpos == 20) found = 1'b1;
      else step(1);
    end
    check("rst_mid_reach", {63'd0, found}, 64'd1);
    rst = 1'b1; step(1);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    step(2); rst = 1'b0; step(80);

    // Random traffic with sparse captures.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      ready = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) begin fill_rand(); cnt = 4'd0; end
      else cnt = 4'd7;
      step(1);
    end
    // Free-running 16-cycle phase counter: captures outpace the drain.
    for (int c = 0; c < 600; c++) begin
      ready = ($urandom_range(7) != 0);
      cnt = 4'(c);
      if (cnt == 4'd15) fill_rand();
      step(1);
    end
    cnt = 4'd7; ready = 1'b1; step(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
